// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ byte sources.
// Grants one byte per transfer, handshakes on tx_busy, and aborts a send the transmitter never picks up.
module uart_tx_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic               src_clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  input  logic               tx_busy,
  output logic               tx_en,
  output logic               tx_send,
  output logic [7:0]         tx_data,
  output logic [N_REQ-1:0]   last_grant,
  output logic               timeout_err,
  output logic [7:0]         err_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gnt;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_ack;
  logic             r_tx_en;
  logic             r_tx_send;
  logic [7:0]       r_tx_data;
  logic [N_REQ-1:0] r_last_grant;
  logic             r_timeout_err;
  logic [7:0]       r_err_count;

  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_next_ptr;
  logic [N_REQ-1:0] w_onehot;

  // Rotating priority search: scan from the highest offset down so the
  // requester closest to r_ptr overwrites the others and wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % N_REQ);
      if (req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign w_onehot   = N_REQ'(1) << w_idx;
  assign w_next_ptr = (r_gnt == IDX_W'(N_REQ - 1)) ? '0 : r_gnt + IDX_W'(1);

  always_ff @(posedge src_clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_gnt         <= '0;
      r_cnt         <= '0;
      r_ack         <= '0;
      r_tx_en       <= 1'b0;
      r_tx_send     <= 1'b0;
      r_tx_data     <= '0;
      r_last_grant  <= '0;
      r_timeout_err <= 1'b0;
      r_err_count   <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      r_ack         <= '0;
      r_timeout_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!tx_busy && w_found) begin
            r_gnt        <= w_idx;
            r_tx_data    <= req_data[{w_idx, 3'b000} +: 8];
            r_last_grant <= w_onehot;
            r_tx_send    <= 1'b1;
            r_tx_en      <= 1'b1;
            r_cnt        <= '0;
            r_state      <= SEND;
          end
        end
        SEND: begin
          // busy on the final count still wins over the abort
          if (tx_busy) begin
            r_tx_send <= 1'b0;
            r_ack     <= r_last_grant;
            r_state   <= WAIT_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_tx_send     <= 1'b0;
            r_tx_en       <= 1'b0;
            r_timeout_err <= 1'b1;
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            r_ptr   <= w_next_ptr;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            r_ptr   <= w_next_ptr;
            r_tx_en <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack         = r_ack;
  assign tx_en       = r_tx_en;
  assign tx_send     = r_tx_send;
  assign tx_data     = r_tx_data;
  assign last_grant  = r_last_grant;
  assign timeout_err = r_timeout_err;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table for a single transfer, then
// hand-written sequences for round-robin, reset, busy-at-start, timeout and saturation.
module tb_uart_tx_arbiter;

  logic src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  // Main instance, short timeout
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [15:0] req_data = '0;
  logic        tx_busy = 1'b0;
  logic [1:0]  ack;
  logic        tx_en, tx_send, timeout_err;
  logic [7:0]  tx_data, err_count;
  logic [1:0]  last_grant;

  uart_tx_arbiter #(.N_REQ(2), .TIMEOUT(16), .CNT_W(16)) dut (
    .src_clk(src_clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_busy(tx_busy), .tx_en(tx_en), .tx_send(tx_send), .tx_data(tx_data),
    .last_grant(last_grant), .timeout_err(timeout_err), .err_count(err_count)
  );

  // Saturation instance, minimum timeout
  logic        rst_s = 1'b1;
  logic [1:0]  req_s = 2'b01;
  logic [15:0] req_data_s = 16'h005A;
  logic        tx_busy_s = 1'b0;
  logic [1:0]  ack_s;
  logic        tx_en_s, tx_send_s, timeout_err_s;
  logic [7:0]  tx_data_s, err_count_s;
  logic [1:0]  last_grant_s;

  uart_tx_arbiter #(.N_REQ(2), .TIMEOUT(2), .CNT_W(2)) dut_sat (
    .src_clk(src_clk), .rst(rst_s), .req(req_s), .req_data(req_data_s), .ack(ack_s),
    .tx_busy(tx_busy_s), .tx_en(tx_en_s), .tx_send(tx_send_s), .tx_data(tx_data_s),
    .last_grant(last_grant_s), .timeout_err(timeout_err_s), .err_count(err_count_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       busy;
    int         n;
    logic [1:0] ack;
    logic       en;
    logic       send;
    logic [7:0] data;
    logic [1:0] lg;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge src_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_send(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx_send) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check($sformatf("%s.send_seen", name), 32'(ok), 1);
  endtask

  // One full transfer: busy rises so tx_send is high for `delay` cycles, then held `hold` cycles.
  task automatic serve(input string name, input logic [7:0] exp_data, input logic [1:0] exp_gnt,
                       input int delay, input int hold, input bit rearm);
    bit ok;
    wait_send(name, ok);
    if (!ok) return;
    check($sformatf("%s.data", name), 32'(tx_data), 32'(exp_data));
    check($sformatf("%s.grant", name), 32'(last_grant), 32'(exp_gnt));
    repeat (delay - 1) tick();
    check($sformatf("%s.send_held", name), 32'(tx_send), 1);
    tx_busy = 1'b1;
    tick();
    check($sformatf("%s.ack", name), 32'(ack), 32'(exp_gnt));
    check($sformatf("%s.send_drop", name), 32'(tx_send), 0);
    check($sformatf("%s.no_terr", name), 32'(timeout_err), 0);
    req = req & ~exp_gnt;
    tick();
    check($sformatf("%s.ack_pulse", name), 32'(ack), 0);
    if (rearm) req = req | exp_gnt;
    repeat (hold) tick();
    tx_busy = 1'b0;
    tick();
    check($sformatf("%s.en_fall", name), 32'(tx_en), 0);
  endtask

  initial begin
    bit ok;
    int n;
    int pulses;
    int bad;
    int cycles;
    logic [7:0] prev;

    //        rst   req    busy  n   ack    en    send  data   lg
    vecs[0] = '{1'b1, 2'b00, 1'b0, 2,  2'b00, 1'b0, 1'b0, 8'h00, 2'b00};
    vecs[1] = '{1'b0, 2'b01, 1'b0, 1,  2'b00, 1'b1, 1'b1, 8'h41, 2'b01};
    vecs[2] = '{1'b0, 2'b01, 1'b0, 2,  2'b00, 1'b1, 1'b1, 8'h41, 2'b01};
    vecs[3] = '{1'b0, 2'b01, 1'b1, 1,  2'b01, 1'b1, 1'b0, 8'h41, 2'b01};
    vecs[4] = '{1'b0, 2'b00, 1'b1, 19, 2'b00, 1'b1, 1'b0, 8'h41, 2'b01};
    vecs[5] = '{1'b0, 2'b00, 1'b0, 1,  2'b00, 1'b0, 1'b0, 8'h41, 2'b01};
    vecs[6] = '{1'b0, 2'b00, 1'b0, 3,  2'b00, 1'b0, 1'b0, 8'h41, 2'b01};

    // Single transfer, cycle by cycle
    req_data = 16'h9941;
    for (int v = 0; v < 7; v++) begin
      for (int c = 0; c < vecs[v].n; c++) begin
        rst     = vecs[v].rst;
        req     = vecs[v].req;
        tx_busy = vecs[v].busy;
        tick();
        check($sformatf("v%0d.%0d.ack", v, c),  32'(ack),        32'(vecs[v].ack));
        check($sformatf("v%0d.%0d.en", v, c),   32'(tx_en),      32'(vecs[v].en));
        check($sformatf("v%0d.%0d.send", v, c), 32'(tx_send),    32'(vecs[v].send));
        check($sformatf("v%0d.%0d.data", v, c), 32'(tx_data),    32'(vecs[v].data));
        check($sformatf("v%0d.%0d.lg", v, c),   32'(last_grant), 32'(vecs[v].lg));
        check($sformatf("v%0d.%0d.terr", v, c), 32'(timeout_err), 0);
        check($sformatf("v%0d.%0d.ecnt", v, c), 32'(err_count),  0);
      end
    end

    // Round robin with both requesters held
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    req_data = 16'h2211;
    req      = 2'b11;
    serve("rr0", 8'h11, 2'b01, 3, 4, 1'b1);
    serve("rr1", 8'h22, 2'b10, 3, 4, 1'b1);
    serve("rr2", 8'h11, 2'b01, 3, 4, 1'b1);
    serve("rr3", 8'h22, 2'b10, 3, 4, 1'b1);

    // Leave r_ptr pointing at requester 1, then reset while in WAIT_DONE
    req = 2'b01;
    serve("pre", 8'h11, 2'b01, 3, 2, 1'b0);
    req = 2'b10;
    wait_send("mid", ok);
    check("mid.grant", 32'(last_grant), 32'(2'b10));
    tick();
    tx_busy = 1'b1;
    tick();
    check("mid.ack", 32'(ack), 32'(2'b10));
    req = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    check("rst.ack",  32'(ack), 0);
    check("rst.en",   32'(tx_en), 0);
    check("rst.send", 32'(tx_send), 0);
    check("rst.data", 32'(tx_data), 0);
    check("rst.lg",   32'(last_grant), 0);
    check("rst.terr", 32'(timeout_err), 0);
    check("rst.ecnt", 32'(err_count), 0);

    // Transmitter still busy at release: no grant until it falls
    rst = 1'b0;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("busy_hold%0d.send", i), 32'(tx_send), 0);
      check($sformatf("busy_hold%0d.en", i), 32'(tx_en), 0);
    end
    tx_busy = 1'b0;
    tick();
    check("busy_fall.send", 32'(tx_send), 1);
    check("busy_fall.lg",   32'(last_grant), 32'(2'b01));
    check("busy_fall.data", 32'(tx_data), 32'h11);
    serve("busy_fall", 8'h11, 2'b01, 3, 2, 1'b0);

    // Timeout: tx_send high exactly 16 cycles, then a retry of the same byte
    req = 2'b01;
    wait_send("to", ok);
    n   = 1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ack != 2'b00) bad++;
      if (!tx_send) break;
      n++;
    end
    check("to.send_len", 32'(n), 16);
    check("to.no_ack",   32'(bad), 0);
    check("to.terr",     32'(timeout_err), 1);
    check("to.ecnt",     32'(err_count), 1);
    check("to.en",       32'(tx_en), 0);
    tick();
    check("to.terr_pulse", 32'(timeout_err), 0);
    check("to.retry_send", 32'(tx_send), 1);
    check("to.retry_data", 32'(tx_data), 32'h11);
    // Busy arriving on the last count is a success
    req = 2'b01;
    serve("edge", 8'h11, 2'b01, 16, 2, 1'b0);
    check("edge.ecnt", 32'(err_count), 1);

    // Saturation of err_count over 300 aborted attempts
    rst_s  = 1'b0;
    pulses = 0;
    bad    = 0;
    cycles = 0;
    prev   = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      tick();
      cycles++;
      if (timeout_err_s) pulses++;
      if (ack_s != 2'b00) bad++;
      if (err_count_s != ((pulses > 255) ? 8'hFF : 8'(pulses))) bad++;
      if (err_count_s < prev) bad++;
      prev = err_count_s;
      if (pulses >= 300) break;
    end
    check("sat.pulses", 32'(pulses), 300);
    check("sat.cycles", 32'(cycles), 900);
    check("sat.model",  32'(bad), 0);
    check("sat.ecnt",   32'(err_count_s), 32'hFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between N_REQ byte sources, e.g. manual switch byte, RX echo/loopback and a future status reporter.
- Round-robin arbitration, one byte per grant.
- Drives the transmitter's enable, send strobe and data; handshakes on its busy flag; recovers from a transmitter that never starts.
- Lives in the src_clk domain next to the Tx/Rx/Baudrate blocks; tx_busy arrives already synchronised to src_clk.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT, 65535, src_clk cycles tx_send may stay high without tx_busy rising before the attempt is aborted (>=2).
- CNT_W, 16, width of the timeout counter; must hold TIMEOUT-1.

Ports:
- src_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request; held high until matching ack.
- req_data  in  8*N_REQ  byte of requester i on bits [8i+7:8i]; stable while req[i] high.
- ack  out  N_REQ  one-cycle pulse: requester's byte accepted by transmitter.
- tx_busy  in  1  transmitter busy flag (synchronised).
- tx_en  out  1  transmitter enable.
- tx_send  out  1  send strobe to transmitter.
- tx_data  out  8  byte presented to transmitter.
- last_grant  out  N_REQ  one-hot owner of current/last transfer (display source).
- timeout_err  out  1  one-cycle pulse on aborted attempt.
- err_count  out  8  saturating count of timeouts.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; ptr=0 (requester 0 checked first); ack, tx_en, tx_send, tx_data, last_grant, timeout_err, err_count, cnt all 0.
- Reset mid-transfer: everything clears on that edge and tx_send drops. A transmission already in progress in Tx finishes on its own; IDLE waits for tx_busy low before the next grant.
- States: IDLE, SEND, WAIT_DONE.
- IDLE:
  - When tx_busy=0 and |req, grant the first set req[i] searching ptr, ptr+1, ... mod N_REQ.
  - At that edge: tx_data<=req_data[i]; last_grant<=onehot(i); tx_send<=1; tx_en<=1; cnt<=0; go to SEND.
  - Latency: tx_send is high the cycle after req is sampled.
  - When tx_busy=1, or no request is present: stay in IDLE, tx_en=0.
- SEND: tx_send=1; cnt increments each cycle.
  - tx_busy=1 sampled: tx_send<=0; ack<=last_grant for one cycle; go to WAIT_DONE.
  - tx_busy=0 and cnt==TIMEOUT-1: tx_send<=0; tx_en<=0; timeout_err<=1 for one cycle; err_count<=err_count+1, saturating at 255; ptr<=granted+1 mod N_REQ; no ack; go to IDLE. The requester keeps req high and re-competes.
  - Result: on timeout, tx_send is high for exactly TIMEOUT cycles.
- WAIT_DONE: tx_en=1.
  - On tx_busy=0: ptr<=granted+1 mod N_REQ; tx_en<=0; go to IDLE.
  - Minimum spacing between two tx_send assertions is 2 cycles after tx_busy falls.
- Simultaneous events:
  - A req change during SEND/WAIT_DONE is ignored; tx_data stays latched.
  - A requester dropping req before ack still has its byte sent.
  - tx_busy high at the same edge cnt reaches TIMEOUT-1 counts as success.
- Fairness: a requester that holds req continuously is granted at most once before every other asserted requester is served.
- ack is one-hot or zero, never multi-bit.

Test Plan:
1. N_REQ=2. req[0]=1, data 0x41; Tx model raises busy 3 cycles after tx_send and holds it 20 cycles -> tx_data=0x41 and tx_send high 3 cycles; ack=01 one cycle; last_grant=01; tx_en falls the cycle after busy falls.
2. req=11 held, data0=0x11, data1=0x22, re-asserted after each ack -> transmitted sequence 0x11,0x22,0x11,0x22; each ack matches its byte.
3. TIMEOUT=16, busy stuck 0, req=01 -> tx_send high exactly 16 cycles; timeout_err one pulse; err_count=1; ack never; retry resumes 1 cycle later with the same byte.
4. tx_busy=1 at reset release with req=01 -> no tx_send until busy falls; tx_send then rises on the next cycle.
5. Reset asserted in WAIT_DONE -> all outputs 0 next cycle; ptr=0; with req=11 after release, requester 0 is granted first.
6. TIMEOUT=2 with busy stuck 0 for 300 attempts -> err_count stops at 255; no wrap to 0.
